// File: rtl/led_pwm_driver.sv
// led_pwm_driver: drives the LEDR pins from the PIO pattern with PWM brightness.
// Pattern and duty are sampled only at PWM period boundaries, so LED updates are glitch-free.
// Optional feature: define LED_BLINK_EN to add the blink_mask port and per-LED blinking.
module led_pwm_driver #(
  parameter int unsigned WIDTH         = 18,
  parameter int unsigned PRESCALE      = 50,
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned BLINK_PERIODS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    pattern_in,
  input  logic [PWM_BITS-1:0] duty,
`ifdef LED_BLINK_EN
  input  logic [WIDTH-1:0]    blink_mask,
`endif
  output logic [WIDTH-1:0]    led_out,
  output logic                frame_start
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Reject configurations that cannot work at elaboration time.
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("led_pwm_driver: PRESCALE must be >= 1");
  end
  if (BLINK_PERIODS < 1) begin : g_bad_blink
    $error("led_pwm_driver: BLINK_PERIODS must be >= 1");
  end

  logic [PS_W-1:0]     prescale_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [WIDTH-1:0]    pat_sh;
  logic [PWM_BITS-1:0] duty_sh;
  logic                tick;
  logic                boundary;
  logic                lit;
  logic [WIDTH-1:0]    led_next;

  assign tick     = (prescale_cnt == PS_W'(PRESCALE - 1));
  assign boundary = tick && (pwm_cnt == {PWM_BITS{1'b1}});
  assign lit      = (pwm_cnt < duty_sh);

`ifdef LED_BLINK_EN
  localparam int unsigned BC_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

  logic [BC_W-1:0]  blink_cnt;
  logic             blink_phase;
  logic [WIDTH-1:0] blink_mask_sh;

  // Blink state advances once per PWM period; phase 0 hides masked LEDs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt     <= '0;
      blink_phase   <= 1'b1;
      blink_mask_sh <= '0;
    end else if (boundary) begin
      blink_mask_sh <= blink_mask;
      if (blink_cnt == BC_W'(BLINK_PERIODS - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BC_W'(1);
      end
    end
  end

  assign led_next = pat_sh & {WIDTH{lit}} & ~(blink_mask_sh & {WIDTH{~blink_phase}});
`else
  assign led_next = pat_sh & {WIDTH{lit}};
`endif

  // Prescaler: one PWM count step every PRESCALE clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_cnt <= '0;
    end else if (tick) begin
      prescale_cnt <= '0;
    end else begin
      prescale_cnt <= prescale_cnt + PS_W'(1);
    end
  end

  // PWM counter plus boundary capture of pattern and duty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt     <= '0;
      pat_sh      <= '0;
      duty_sh     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (boundary) begin
        pwm_cnt <= '0;
        pat_sh  <= pattern_in;
        duty_sh <= duty;
      end else if (tick) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
    end
  end

  // Registered LED drive, one clock behind the counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out <= '0;
    end else begin
      led_out <= led_next;
    end
  end

endmodule
